// File: rtl/periph_handshake_rx_pkg.sv
// Shared handshake definitions: FSM state encoding and the data width
// common to the CPU-side FSM and this peripheral-side responder.
package periph_handshake_rx_pkg;

  localparam int HS_DATA_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PROC = 2'b01,
    ACK  = 2'b10
  } hs_state_t;

endpackage

// File: rtl/periph_handshake_rx_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level (the CPU send strobe).
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk1,
  input  logic rst1,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw level through the flop chain; the last stage is the safe copy.
  always_ff @(posedge clk1) begin
    // NOTE: rst1 is synchronous; it is only seen on the clock edge and wins over the shift.
    if (rst1) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/periph_handshake_rx.sv
// Peripheral-side responder for the 4-phase send/ack handshake.
// Captures dado when the synchronised send is seen in IDLE, waits a fixed
// processing time, then holds ack high until send is seen low again.
module periph_handshake_rx
  import periph_handshake_rx_pkg::*;
#(
  parameter int DATA_W      = HS_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int PROC_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic              clk1,
  input  logic              rst1,
  input  logic              send,
  input  logic [DATA_W-1:0] dado,
  output logic              ack,
  output logic [DATA_W-1:0] dado_rx,
  output logic              rx_valid,
  output logic [CNT_W-1:0]  rx_count
);

  // Down-counter just wide enough to hold PROC_CYCLES-1.
  localparam int PCW = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;
  localparam logic [PCW-1:0] PROC_LOAD = PCW'(PROC_CYCLES - 1);

  hs_state_t      state_q, state_d;
  logic [PCW-1:0] proc_cnt_q, proc_cnt_d;
  logic           send_s;
  logic           capture;
  logic           ack_d;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_send_sync (
    .clk1 (clk1),
    .rst1 (rst1),
    .d    (send),
    .q    (send_s)
  );

  // Next-state, processing counter and capture strobe; decisions use send_s only.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    proc_cnt_d = proc_cnt_q;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (send_s) begin
          state_d    = PROC;
          capture    = 1'b1;
          proc_cnt_d = PROC_LOAD;
        end
      end
      PROC: begin
        if (proc_cnt_q != '0) begin
          proc_cnt_d = proc_cnt_q - PCW'(1);
        end else begin
          state_d = ACK;
        end
      end
      ACK: begin
        if (!send_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // ack is a registered copy of "next state is ACK", so it never glitches.
    ack_d = (state_d == ACK);
  end

  // State register and processing counter.
  always_ff @(posedge clk1) begin
    if (rst1) begin
      state_q    <= IDLE;
      proc_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      proc_cnt_q <= proc_cnt_d;
    end
  end

  // Registered outputs: ack, captured word, one-cycle valid pulse, word count.
  always_ff @(posedge clk1) begin
    if (rst1) begin
      ack      <= 1'b0;
      dado_rx  <= '0;
      rx_valid <= 1'b0;
      rx_count <= '0;
    end else begin
      ack      <= ack_d;
      rx_valid <= capture;
      if (capture) begin
        dado_rx  <= dado;
        rx_count <= rx_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_periph_handshake_rx.sv
// Self-checking bench for periph_handshake_rx. Two instances share the same
// stimulus: one with default parameters, one with CNT_W=2 to exercise wrap.
// Expected outputs come from a timeline model: offsets from the first edge
// that samples send=1 (E0) or send=0 (F0), plus a running transfer total.
module tb_periph_handshake_rx;

  localparam int S = 2;  // SYNC_STAGES
  localparam int P = 3;  // PROC_CYCLES

  logic       clk1 = 1'b0;
  logic       rst1;
  logic       send;
  logic [1:0] dado;

  logic       ack_a, rx_valid_a;
  logic [1:0] dado_rx_a;
  logic [7:0] cnt_a;
  logic       ack_b, rx_valid_b;
  logic [1:0] dado_rx_b;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: transfers since last reset and last captured word.
  int         total     = 0;
  logic [1:0] last_word = '0;

  periph_handshake_rx dut_a (
    .clk1     (clk1),
    .rst1     (rst1),
    .send     (send),
    .dado     (dado),
    .ack      (ack_a),
    .dado_rx  (dado_rx_a),
    .rx_valid (rx_valid_a),
    .rx_count (cnt_a)
  );

  periph_handshake_rx #(
    .CNT_W (2)
  ) dut_b (
    .clk1     (clk1),
    .rst1     (rst1),
    .send     (send),
    .dado     (dado),
    .ack      (ack_b),
    .dado_rx  (dado_rx_b),
    .rx_valid (rx_valid_b),
    .rx_count (cnt_b)
  );

  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  function automatic logic [17:0] exp_vec(input logic a, input logic v);
    return {a, v, last_word, 8'(total), a, v, last_word, 2'(total)};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {ack_a, rx_valid_a, dado_rx_a, cnt_a, ack_b, rx_valid_b, dado_rx_b, cnt_b};
  endfunction

  // One full handshake starting now: send rises, ack is awaited, send drops,
  // ack fall is awaited. Ends in IDLE, ready for a back-to-back send.
  task automatic do_transfer(input logic [1:0] data, input int hold,
                             input bit scramble, input string tag);
    logic [17:0] e;
    dado = data;
    send = 1'b1;
    for (int off = 0; off < S + P + hold; off++) begin
      tick();
      if (off == S) begin
        total++;
        last_word = data;
      end
      e = exp_vec(off >= S + P, off == S);
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL %s rise off=%0d got=%h exp=%h", tag, off, obs_vec(), e);
      end
      if (scramble && off >= S) dado = 2'($urandom);
    end
    send = 1'b0;
    for (int off = 0; off <= S; off++) begin
      tick();
      e = exp_vec(off < S, 1'b0);
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL %s fall off=%0d got=%h exp=%h", tag, off, obs_vec(), e);
      end
    end
  endtask

  task automatic test_reset();
    logic [17:0] e;
    rst1 = 1'b1;
    send = 1'b1;
    dado = 2'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      total     = 0;
      last_word = '0;
      e = exp_vec(1'b0, 1'b0);
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL reset hold cyc=%0d got=%h exp=%h", i, obs_vec(), e);
      end
    end
    rst1 = 1'b0;
    send = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_vec(1'b0, 1'b0);
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL reset idle cyc=%0d got=%h exp=%h", i, obs_vec(), e);
      end
    end
  endtask

  task automatic test_single();
    do_transfer(2'b10, $urandom_range(1, 4), 1'b0, "single");
    n_cmp++;
    if (cnt_a !== 8'd1) begin
      n_bad++;
      $display("FAIL single count got=%0d exp=1", cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_transfer(2'(i), $urandom_range(1, 4), 1'b0, "b2b");
    end
    n_cmp++;
    if (cnt_a !== 8'd5) begin
      n_bad++;
      $display("FAIL b2b count got=%0d exp=5", cnt_a);
    end
  endtask

  // send is high only for the first d+1 sampling edges; ack must pulse once.
  task automatic test_early_drop();
    logic [17:0] e;
    logic [1:0]  data;
    int          d;
    d    = $urandom_range(0, 2);
    data = 2'($urandom);
    dado = data;
    send = 1'b1;
    for (int off = 0; off < 10; off++) begin
      tick();
      if (off == S) begin
        total++;
        last_word = data;
      end
      e = exp_vec(off == S + P, off == S);
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL early_drop d=%0d off=%0d got=%h exp=%h", d, off, obs_vec(), e);
      end
      if (off == d) send = 1'b0;
    end
  endtask

  // Reset lands on E0+4 with send held; a fresh capture follows the release.
  task automatic test_reset_mid();
    logic [17:0] e;
    logic [1:0]  data;
    data = 2'($urandom);
    dado = data;
    send = 1'b1;
    for (int off = 0; off < 4; off++) begin
      tick();
      if (off == S) begin
        total++;
        last_word = data;
      end
      e = exp_vec(1'b0, off == S);
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL rst_mid pre off=%0d got=%h exp=%h", off, obs_vec(), e);
      end
    end
    rst1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total     = 0;
      last_word = '0;
      e = exp_vec(1'b0, 1'b0);
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++;
        $display("FAIL rst_mid during cyc=%0d got=%h exp=%h", i, obs_vec(), e);
      end
    end
    rst1 = 1'b0;
    do_transfer(2'($urandom), $urandom_range(1, 3), 1'b0, "rst_recap");
    n_cmp++;
    if (cnt_a !== 8'd1) begin
      n_bad++;
      $display("FAIL rst_mid count got=%0d exp=1", cnt_a);
    end
  endtask

  task automatic test_wrap();
    logic [17:0] e;
    rst1 = 1'b1;
    send = 1'b0;
    tick();
    rst1      = 1'b0;
    total     = 0;
    last_word = '0;
    e = exp_vec(1'b0, 1'b0);
    n_cmp++;
    if (obs_vec() !== e) begin
      n_bad++;
      $display("FAIL wrap reset got=%h exp=%h", obs_vec(), e);
    end
    for (int i = 0; i < 5; i++) begin
      do_transfer(2'($urandom), $urandom_range(1, 3), 1'b1, "wrap");
      n_cmp++;
      if (cnt_b !== 2'(i + 1)) begin
        n_bad++;
        $display("FAIL wrap count n=%0d got=%0d exp=%0d", i + 1, cnt_b, 2'(i + 1));
      end
    end
  endtask

  // Random words, hold times and idle gaps, with dado scrambled after capture.
  task automatic test_random();
    logic [17:0] e;
    for (int i = 0; i < 8; i++) begin
      do_transfer(2'($urandom), $urandom_range(1, 6), 1'($urandom), "random");
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        dado = 2'($urandom);
        tick();
        e = exp_vec(1'b0, 1'b0);
        n_cmp++;
        if (obs_vec() !== e) begin
          n_bad++;
          $display("FAIL random gap n=%0d got=%h exp=%h", i, obs_vec(), e);
        end
      end
    end
  endtask

  initial begin
    rst1 = 1'b1;
    send = 1'b1;
    dado = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_early_drop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
